// File: rtl/matmul_pkg.sv
// matmul_pkg: constants and types shared by the matrix-multiply datapath
// controllers.
//   DATA_W   - width of one result word
//   SEL_W    - width of the result mux select
//   SEL_NONE - select code meaning "no result selected" (all ones)
//   rd_state_e - result reader FSM encoding
package matmul_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEL_W  = 4;

    localparam logic [SEL_W-1:0] SEL_NONE = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRESENT = 3'd3,
        ST_CLEAR   = 3'd4
    } rd_state_e;

endpackage

// File: rtl/matmul_result_reader.sv
// matmul_result_reader: drains finished product words out of the result
// register bank and streams them on a valid/ready interface.
//
// On a results_ready pulse the reader walks rd_sel over 0..NUM_RESULTS-1.
// Each word takes three cycles: SELECT drives the mux select, CAPTURE
// registers the settled rd_data, PRESENT holds it until the handshake.
// After the last word is accepted, mem_clr and done pulse for one cycle
// to release the bank.
//
// Ports:
//   clk           - system clock, rising edge
//   reset         - asynchronous, active-high reset
//   results_ready - one-cycle pulse: the result bank is stable
//   rd_sel        - result mux select, all ones when idle
//   rd_data       - result mux output, valid one cycle after rd_sel changes
//   dout          - streamed result word
//   dout_valid    - dout holds a word
//   dout_ready    - downstream accepts dout when valid and ready on an edge
//   dout_par      - even parity of dout (only with RESULT_PARITY_EN)
//   busy          - transfer in progress
//   mem_clr       - one-cycle bank clear pulse
//   done          - one-cycle pulse, coincident with mem_clr
//
// Build option: define RESULT_PARITY_EN to add the dout_par output.
module matmul_result_reader #(
    parameter int unsigned DATA_W      = matmul_pkg::DATA_W,
    parameter int unsigned NUM_RESULTS = 9,
    parameter int unsigned SEL_W       = matmul_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              results_ready,
    output logic [SEL_W-1:0]  rd_sel,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
`ifdef RESULT_PARITY_EN
    output logic              dout_par,
`endif
    output logic              busy,
    output logic              mem_clr,
    output logic              done
);

    import matmul_pkg::*;

    localparam logic [SEL_W-1:0] RD_SEL_IDLE = '1;
    localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NUM_RESULTS - 1);

    rd_state_e         state_q, state_d;
    logic [SEL_W-1:0]  index_q, index_d;
    logic [SEL_W-1:0]  rd_sel_q, rd_sel_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              busy_q, busy_d;
    logic              mem_clr_q, mem_clr_d;
    logic              done_q, done_d;
`ifdef RESULT_PARITY_EN
    logic              dout_par_q, dout_par_d;
`endif

    logic handshake;
    logic last_word;

    assign handshake = dout_valid_q & dout_ready;
    assign last_word = (index_q == LAST_IDX);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            rd_sel_q     <= RD_SEL_IDLE;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            mem_clr_q    <= 1'b0;
            done_q       <= 1'b0;
`ifdef RESULT_PARITY_EN
            dout_par_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            rd_sel_q     <= rd_sel_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            mem_clr_q    <= mem_clr_d;
            done_q       <= done_d;
`ifdef RESULT_PARITY_EN
            dout_par_q   <= dout_par_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (results_ready) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (handshake) begin
                    state_d = last_word ? ST_CLEAR : ST_SELECT;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic. All outputs are registered, so each value
    // is computed on the transition that enters the state in which it
    // must be visible (e.g. rd_sel is loaded when entering SELECT, the
    // clear pulse when leaving PRESENT for CLEAR).
    // ------------------------------------------------------------------
    always_comb begin
        index_d      = index_q;
        rd_sel_d     = rd_sel_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        busy_d       = busy_q;
        mem_clr_d    = 1'b0;
        done_d       = 1'b0;
`ifdef RESULT_PARITY_EN
        dout_par_d   = dout_par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                rd_sel_d = RD_SEL_IDLE;
                if (results_ready) begin
                    index_d  = '0;
                    rd_sel_d = '0;
                    busy_d   = 1'b1;
                end
            end
            ST_SELECT: begin
                // rd_sel already holds index; this cycle lets the mux settle.
                rd_sel_d = index_q;
            end
            ST_CAPTURE: begin
                dout_d       = rd_data;
                dout_valid_d = 1'b1;
`ifdef RESULT_PARITY_EN
                dout_par_d   = ^rd_data;
`endif
            end
            ST_PRESENT: begin
                if (handshake) begin
                    dout_valid_d = 1'b0;
                    if (last_word) begin
                        mem_clr_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        index_d  = index_q + SEL_W'(1);
                        rd_sel_d = index_q + SEL_W'(1);
                    end
                end
            end
            ST_CLEAR: begin
                rd_sel_d = RD_SEL_IDLE;
                busy_d   = 1'b0;
            end
            default: begin
                rd_sel_d     = RD_SEL_IDLE;
                dout_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    assign rd_sel     = rd_sel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign mem_clr    = mem_clr_q;
    assign done       = done_q;
`ifdef RESULT_PARITY_EN
    assign dout_par   = dout_par_q;
`endif

endmodule

// File: tb/tb_matmul_result_reader.sv
// Self-checking bench for matmul_result_reader. A cycle-timeline model
// (words due every third cycle after each acceptance, clear pulse one
// cycle after the last acceptance) is checked every cycle on the falling
// edge; directed scenarios pin the model with literal expectations.
module tb_matmul_result_reader;

    localparam int NUM = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        results_ready;
    logic [3:0]  rd_sel;
    logic [15:0] rd_data;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        mem_clr;
    logic        done;
`ifdef RESULT_PARITY_EN
    logic        dout_par;
`endif

    matmul_result_reader #(
        .DATA_W      (16),
        .NUM_RESULTS (NUM),
        .SEL_W       (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .results_ready (results_ready),
        .rd_sel        (rd_sel),
        .rd_data       (rd_data),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
`ifdef RESULT_PARITY_EN
        .dout_par      (dout_par),
`endif
        .busy          (busy),
        .mem_clr       (mem_clr),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Result bank with a registered mux: data follows rd_sel one cycle later.
    logic [15:0] bank [16];
    always @(posedge clk) rd_data <= bank[rd_sel];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model and per-cycle compare
    // ------------------------------------------------------------------
    int          cyc = 0;
    bit          m_busy = 1'b0;
    int          m_idx = 0;
    int          m_nv = 0;
    int          m_clr = -1;
    bit          e_valid;
    bit          e_clr;
    logic [3:0]  e_sel;
    int          words_seen = 0;
    int          clr_seen = 0;
    logic [15:0] word_log [$];
    logic        par_log [$];

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_rd_sel", rd_sel, 4'hF);
            chk("rst_dout", dout, 16'h0);
            chk("rst_valid", dout_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mem_clr", mem_clr, 0);
            chk("rst_done", done, 0);
`ifdef RESULT_PARITY_EN
            chk("rst_par", dout_par, 0);
`endif
            m_busy = 1'b0;
            m_clr  = -1;
        end else begin
            e_valid = m_busy && (m_clr < 0) && (cyc >= m_nv);
            e_clr   = m_busy && (cyc == m_clr);
            e_sel   = !m_busy ? 4'hF : (e_clr ? 4'(NUM - 1) : 4'(m_idx));
            chk("valid", dout_valid, e_valid);
            chk("busy", busy, m_busy);
            chk("mem_clr", mem_clr, e_clr);
            chk("done", done, e_clr);
            chk("rd_sel", rd_sel, e_sel);
            if (e_valid) begin
                chk("dout", dout, bank[m_idx]);
`ifdef RESULT_PARITY_EN
                chk("dout_par", dout_par, ^bank[m_idx]);
`endif
            end
            if (mem_clr) clr_seen++;

            if (e_clr) begin
                m_busy = 1'b0;
            end else if (e_valid && dout_ready) begin
                word_log.push_back(dout);
`ifdef RESULT_PARITY_EN
                par_log.push_back(dout_par);
`else
                par_log.push_back(^dout);
`endif
                words_seen++;
                if (m_idx == NUM - 1) m_clr = cyc + 1;
                else begin
                    m_idx++;
                    m_nv = cyc + 3;
                end
            end else if (!m_busy && results_ready) begin
                m_busy = 1'b1;
                m_idx  = 0;
                m_nv   = cyc + 3;
                m_clr  = -1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // One transfer. stall_w: word value held with ready low for 5 cycles;
    // repulse_w: word value during which results_ready is pulsed again;
    // reset_w: word value at which reset is asserted; rnd: random ready
    // and random extra results_ready pulses. Returns latency to first
    // valid (counting the pulse cycle) and cycles from IDLE exit to idle.
    task automatic transfer(input int stall_w, input int repulse_w, input int reset_w,
                            input bit rnd, output int lat, output int tot);
        int stalled;
        bit repulsed;
        stalled  = 0;
        repulsed = 1'b0;
        lat = -1;
        tot = -1;
        words_seen = 0;
        clr_seen   = 0;
        word_log.delete();
        par_log.delete();
        results_ready = 1'b1;
        dout_ready    = 1'b1;
        @(posedge clk); #1;
        results_ready = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (lat < 0 && dout_valid) lat = c + 1;
            if (!busy) begin
                tot = c;
                break;
            end
            if (reset_w > 0 && dout_valid && dout == 16'(reset_w)) begin
                reset = 1'b1;
                #1;
                chk("rst_mid_valid", dout_valid, 0);
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_clr", mem_clr, 0);
                chk("rst_mid_sel", rd_sel, 4'hF);
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
                results_ready = 1'b0;
                dout_ready    = 1'b1;
                return;
            end
            if (rnd) results_ready = ($urandom_range(0, 9) == 0);
            else if (repulse_w > 0 && !repulsed && dout_valid && dout == 16'(repulse_w)) begin
                results_ready = 1'b1;
                repulsed = 1'b1;
            end else results_ready = 1'b0;
            if (dout_valid && dout == 16'(stall_w) && stalled < 5) begin
                dout_ready = 1'b0;
                stalled++;
            end else begin
                dout_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            @(posedge clk); #1;
        end
        results_ready = 1'b0;
        dout_ready    = 1'b1;
        chk("xfer_finished", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_nwords"}, words_seen, NUM);
        chk({tag, "_nclr"}, clr_seen, 1);
        for (int i = 0; i < NUM; i++) begin
            chk({tag, "_word"}, (i < word_log.size()) ? word_log[i] : 16'hxxxx, bank[i]);
        end
    endtask

    int lat, tot;

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = (i < NUM) ? 16'(i + 1) : 16'h0;
        reset         = 1'b1;
        results_ready = 1'b1;
        dout_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1 results_ready = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_sel", rd_sel, 4'hF);
        chk("post_rst_clr_seen", clr_seen, 0);

        // Nominal transfer of 0001..0009.
        transfer(0, 0, 0, 1'b0, lat, tot);
        chk("t1_latency", lat, 3);
        chk("t1_total", tot, 3 * NUM + 1);
        check_words("t1");
        chk("t1_first", word_log.size() > 0 ? word_log[0] : 16'hxxxx, 16'h0001);
        chk("t1_last", word_log.size() > 8 ? word_log[8] : 16'hxxxx, 16'h0009);
        chk("t1_par_w3", par_log.size() > 2 ? par_log[2] : 1'bx, 1'b0);
        chk("t1_par_w7", par_log.size() > 6 ? par_log[6] : 1'bx, 1'b1);

        // Backpressure on word 4 for 5 cycles.
        transfer(4, 0, 0, 1'b0, lat, tot);
        chk("t2_total", tot, 3 * NUM + 1 + 5);
        check_words("t2");

        // Extra results_ready during word 2 is ignored.
        transfer(0, 2, 0, 1'b0, lat, tot);
        chk("t3_total", tot, 3 * NUM + 1);
        check_words("t3");

        // Reset while presenting word 6.
        transfer(0, 0, 6, 1'b0, lat, tot);
        chk("t4_words", words_seen, 5);
        chk("t4_clr", clr_seen, 0);
        repeat (2) @(posedge clk);
        #1;

        // Fresh pulse restarts from word 0001.
        transfer(0, 0, 0, 1'b0, lat, tot);
        chk("t5_latency", lat, 3);
        check_words("t5");

        // Randomized data, ready and spurious pulses.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NUM; i++) bank[i] = 16'($urandom);
            transfer($urandom_range(0, 1) ? int'(bank[$urandom_range(0, NUM - 1)]) : 0,
                     0, 0, 1'b1, lat, tot);
            chk("rnd_latency", lat, 3);
            check_words("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/matmul_result_reader.md
Name: matmul_result_reader

Overview:
- Output-side counterpart to the matrix-multiply load/MAC controller. It drains the finished product results out of the result register bank.
- On a results_ready pulse it walks the result mux select lines, captures each word, and streams it on a dout valid/ready handshake.
- After the last word is accepted it pulses mem_clr to release the bank for the next cf_load cycle.

Parameters:
- DATA_W, 16, width of each result word and of dout.
- NUM_RESULTS, 9, number of result words drained per transfer (1..15).
- SEL_W, 4, width of rd_sel. The all-ones code means "no result selected".

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- results_ready  input  1  one-cycle pulse from the controller: the result bank is stable.
- rd_sel  output  SEL_W  select for the final result mux; all-ones when idle.
- rd_data  input  DATA_W  mux output; valid one cycle after rd_sel changes.
- dout  output  DATA_W  streamed result word.
- dout_valid  output  1  dout holds a word.
- dout_ready  input  1  downstream accepts the word when dout_valid=1 and dout_ready=1 on a rising edge.
- busy  output  1  high from the cycle after results_ready until mem_clr completes.
- mem_clr  output  1  one-cycle pulse that clears the result bank.
- done  output  1  one-cycle pulse, coincident with mem_clr.

Behaviour:
- Reset values (async, immediate):
  - state=IDLE, index=0, rd_sel=all-ones.
  - dout=0, dout_valid=0, busy=0, mem_clr=0, done=0.
- FSM states are IDLE, SELECT, CAPTURE, PRESENT, CLEAR. All outputs are registered.
- IDLE:
  - rd_sel=all-ones.
  - results_ready=1 -> SELECT with index=0, busy=1.
  - results_ready is ignored in every other state; no queuing.
- SELECT: rd_sel=index; go to CAPTURE. This cycle covers the mux settle latency.
- CAPTURE: dout<=rd_data, dout_valid<=1; go to PRESENT.
- PRESENT:
  - dout and dout_valid hold stable until the handshake.
  - On handshake: dout_valid<=0.
    - If index==NUM_RESULTS-1 -> CLEAR.
    - Otherwise index<=index+1 -> SELECT.
- CLEAR:
  - mem_clr=1 and done=1 for exactly one cycle.
  - rd_sel<=all-ones, busy<=0 on exit -> IDLE.
- Latency:
  - results_ready to first dout_valid = 3 cycles.
  - With dout_ready tied high, one word per 3 cycles.
  - Total transfer = 3*NUM_RESULTS + 1 cycles after the IDLE exit.
- Backpressure: dout_ready low holds PRESENT indefinitely with no data change. dout_ready asserted while dout_valid=0 has no effect.
- Index arithmetic:
  - index is SEL_W bits and never reaches all-ones, since NUM_RESULTS<=15.
  - No wrap within a transfer; index resets to 0 at each start.
- Reset mid-transfer: returns to IDLE immediately; no mem_clr or done pulse is issued.

Optional Feature:
- Macro: RESULT_PARITY_EN.
- Defined:
  - Adds output port dout_par (1 bit) = even parity (XOR reduction) of the captured word.
  - dout_par is registered in CAPTURE with dout and is 0 in reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package matmul_pkg holds:
  - DATA_W and SEL_W constants.
  - SEL_NONE = all-ones select code.
  - The FSM state encoding, 3-bit: IDLE=0, SELECT=1, CAPTURE=2, PRESENT=3, CLEAR=4.
- No sub-module is needed; the reader is a single FSM plus a counter.

Test Plan:
- Reset with results_ready high -> all outputs at reset values, rd_sel=4'b1111, and no transfer starts until reset falls and a fresh pulse arrives.
- Result bank preloaded with 16'h0001..16'h0009, dout_ready=1, one results_ready pulse:
  - first dout_valid 3 cycles later;
  - 9 words 0001..0009 in order;
  - rd_sel sequence 0..8;
  - single mem_clr/done pulse;
  - busy low afterwards.
- Same load with dout_ready low for 5 cycles on word 4 -> dout holds 16'h0004 stable with valid high; resumes on ready; no word lost or duplicated.
- results_ready pulsed again during word 2 -> ignored; exactly 9 words and one mem_clr.
- reset asserted while presenting word 6 -> immediate IDLE, dout_valid=0, no mem_clr; a subsequent pulse restarts from word 0001.
- RESULT_PARITY_EN defined, data 16'h0007 -> dout_par=1; data 16'h0003 -> dout_par=0.
